// File: rtl/addsub_word_sequencer_pkg.sv
// Shared constants for the word-serial add/subtract sequencer: FSM state codes,
// opcode values and index-width helpers.
package addsub_word_sequencer_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // A single-word operand still needs a one-bit index register.
    function automatic int idx_width(input int words);
        return (clog2(words) < 1) ? 1 : clog2(words);
    endfunction

endpackage

// File: rtl/addsub_word_sequencer_slice.sv
// Purely combinational BITWIDTH-bit slice: sum = a + (sub ? ~b : b) + cin.
module addsub_word_slice
    import addsub_word_sequencer_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic [BITWIDTH-1:0] sum,
    output logic                cout
);

    logic [BITWIDTH-1:0] b_eff;
    logic [BITWIDTH:0]   total;

    always_comb begin
        b_eff = (sub == OP_SUB) ? ~b : b;
        total = {1'b0, a} + {1'b0, b_eff} + {{BITWIDTH{1'b0}}, cin};
        sum   = total[BITWIDTH-1:0];
        cout  = total[BITWIDTH];
    end

endmodule

// File: rtl/addsub_word_sequencer.sv
// Word-serial wide add/subtract: one BITWIDTH slice, LSB word first, carry held
// between words. Optional signed-overflow flag under macro ADDSUB_SEQ_OVF_EN.
module addsub_word_sequencer
    import addsub_word_sequencer_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int WORDS    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sub,
    input  logic [BITWIDTH*WORDS-1:0] a,
    input  logic [BITWIDTH*WORDS-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [BITWIDTH*WORDS-1:0] result,
    output logic                      cout
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    output logic                      ovf
`endif
);

    localparam int W     = BITWIDTH * WORDS;
    localparam int IDX_W = idx_width(WORDS);
    localparam int MSB   = BITWIDTH - 1;

    logic [1:0]       state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic             sub_q,    sub_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q,   cout_d;
`ifdef ADDSUB_SEQ_OVF_EN
    logic             ovf_q,    ovf_d;
    logic             b_eff_msb;
`endif

    logic [BITWIDTH-1:0] a_words [WORDS];
    logic [BITWIDTH-1:0] b_words [WORDS];
    logic [BITWIDTH-1:0] a_w;
    logic [BITWIDTH-1:0] b_w;
    logic [BITWIDTH-1:0] slice_sum;
    logic                slice_cout;
    logic                last_word;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_words
            assign a_words[gi] = a_q[gi*BITWIDTH +: BITWIDTH];
            assign b_words[gi] = b_q[gi*BITWIDTH +: BITWIDTH];
        end
    endgenerate

    assign a_w       = a_words[idx_q];
    assign b_w       = b_words[idx_q];
    assign last_word = (idx_q == IDX_W'(WORDS - 1));

    addsub_word_slice #(
        .BITWIDTH (BITWIDTH)
    ) u_slice (
        .a    (a_w),
        .b    (b_w),
        .sub  (sub_q),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

`ifdef ADDSUB_SEQ_OVF_EN
    assign b_eff_msb = b_w[MSB] ^ (sub_q == OP_SUB);
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef ADDSUB_SEQ_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // Subtract seeds the chain with carry=1 to complete the two's complement.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = (sub == OP_SUB);
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        result_d[w*BITWIDTH +: BITWIDTH] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (last_word) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
`ifdef ADDSUB_SEQ_OVF_EN
                    ovf_d   = (a_w[MSB] == b_eff_msb) && (slice_sum[MSB] != a_w[MSB]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef ADDSUB_SEQ_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Status flags come straight from the state register, so they are glitch-free.
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
`ifdef ADDSUB_SEQ_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_word_sequencer.sv
// Self-checking bench for addsub_word_sequencer (BITWIDTH=8, WORDS=4): arithmetic
// reference model with cycle-accurate busy/done expectations plus directed cases.
module tb_addsub_word_sequencer;

    localparam int BW = 8;
    localparam int WN = 4;
    localparam int W  = BW * WN;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef ADDSUB_SEQ_OVF_EN
    logic         ovf;
`endif

    addsub_word_sequencer #(
        .BITWIDTH (BW),
        .WORDS    (WN)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub_in),
        .a      (a_in),
        .b      (b_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef ADDSUB_SEQ_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: age = clock edges since the accepting edge (-1 = nothing issued).
    int           age = -1;
    logic [W-1:0] pend_res, hold_res;
    logic         pend_cout, hold_cout;
    logic         pend_ovf, hold_ovf;

    task automatic compute(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           output logic [W-1:0] r, output logic c, output logic o);
        longint sx, sy, sr;
        logic [W:0] wide;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r  = x - y;
            c  = (x >= y);
            sr = sx - sy;
        end else begin
            wide = {1'b0, x} + {1'b0, y};
            r  = wide[W-1:0];
            c  = wide[W];
            sr = sx + sy;
        end
        o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age = -1;
            hold_res = '0;
            hold_cout = 1'b0;
            hold_ovf = 1'b0;
        end else if (start && (age < 0 || age >= WN)) begin
            age = 0;
            compute(a_in, b_in, sub_in, pend_res, pend_cout, pend_ovf);
        end else if (age >= 0 && age <= WN) begin
            age++;
            if (age == WN) begin
                hold_res  = pend_res;
                hold_cout = pend_cout;
                hold_ovf  = pend_ovf;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {63'd0, busy}, {63'd0, (age >= 0 && age < WN)});
            chk("done", {63'd0, done}, {63'd0, (age == WN)});
            if (!(age >= 0 && age < WN)) begin
                chk("result", {32'd0, result}, {32'd0, hold_res});
                chk("cout", {63'd0, cout}, {63'd0, hold_cout});
`ifdef ADDSUB_SEQ_OVF_EN
                chk("ovf", {63'd0, ovf}, {63'd0, hold_ovf});
`endif
            end
        end
    end

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        start  = 1'b1;
        a_in   = x;
        b_in   = y;
        sub_in = s;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called at the first negedge after acceptance (n0=1) or later; returns on the done cycle.
    task automatic wait_done(input string name, input int n0, input logic [W-1:0] exp_res,
                             input logic exp_cout, input logic exp_ovf);
        int n;
        int busy_cnt;
        n = n0;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(WN + 1));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(WN + 1 - n0));
        chk({name, "_result"}, {32'd0, result}, {32'd0, exp_res});
        chk({name, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
`ifdef ADDSUB_SEQ_OVF_EN
        chk({name, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
`else
        if (exp_ovf) begin end
`endif
        $display("op %s: result=%08h cout=%0b latency=%0d", name, result, cout, n);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        sub_in = 1'b0;
        a_in   = '0;
        b_in   = '0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        launch(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_done("ripple", 1, 32'h0000_0100, 1'b0, 1'b0);
        @(negedge clk);
        launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("wrap_add", 1, 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clk);
        launch(32'h0000_0000, 32'h0000_0001, 1'b1);
        wait_done("wrap_sub", 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("sovf_add", 1, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clk);
        launch(32'h1234_5678, 32'h0234_5678, 1'b1);
        wait_done("sub_noovf", 1, 32'h1000_0000, 1'b1, 1'b0);

        // Back-to-back: start held in the done cycle with new operands.
        launch(32'h0000_0005, 32'h0000_0003, 1'b0);
        wait_done("b2b", 1, 32'h0000_0008, 1'b0, 1'b0);

        // Start during RUN with different operands must be ignored.
        @(negedge clk);
        launch(32'h0000_1000, 32'h0000_0234, 1'b0);
        start = 1'b1;
        a_in  = 32'hDEAD_BEEF;
        b_in  = 32'h1111_1111;
        sub_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start", 2, 32'h0000_1234, 1'b0, 1'b0);

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        launch(32'h0102_0304, 32'h0101_0101, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_result", {32'd0, result}, 64'd0);
        chk("midrst_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        launch(32'h0102_0304, 32'h0101_0101, 1'b0);
        wait_done("after_rst", 1, 32'h0203_0405, 1'b0, 1'b0);

        // Random traffic, including starts during RUN and back-to-back issues.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 2) == 0);
            a_in   = pick();
            b_in   = pick();
            sub_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_word_sequencer.md
# addsub_word_sequencer

Multi-cycle wide adder/subtractor controller. Computes a WORDS×BITWIDTH-bit add or subtract with a single BITWIDTH-bit adder/subtractor slice, one word per clock, LSB word first, with the inter-word carry held in a register. Sits between the bus-side command logic and the arithmetic datapath. Trades latency for area wherever operands exceed the native slice width.

## Interface
- BITWIDTH, 8, width of one adder slice and one word
- WORDS, 4, number of words per operand (≥1); total width W = BITWIDTH*WORDS
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE or DONE
- sub  in  1  0 = a+b, 1 = a−b; sampled with start
- a  in  W  operand A; sampled with start
- b  in  W  operand B; sampled with start
- busy  out  1  high while words are being computed
- done  out  1  one-cycle pulse: result, cout and ovf are valid
- result  out  W  registered result; holds until the next accepted start
- cout  out  1  final carry (add: unsigned overflow; sub: 1 = no borrow, a ≥ b)
- ovf  out  1  signed overflow (only with the macro; otherwise absent)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b and sub; idx←0; carry←sub; go to RUN.
- RUN: idx selects word w.
  - result[w] ← a_w + (sub ? ~b_w : b_w) + carry, modulo 2^BITWIDTH.
  - carry ← slice carry-out.
  - idx increments. On idx = WORDS−1, go to DONE.
- DONE: done=1 for this cycle only.
  - cout ← final carry, registered on entry to DONE.
  - start=1 in DONE behaves as in IDLE and goes to RUN directly. Otherwise go to IDLE.
- start while in RUN is ignored. Latched operands are unaffected by input changes after acceptance.
- result words not yet written keep their previous values until overwritten. Only the done cycle guarantees a coherent result.
- idx width is clog2(WORDS), minimum 1. With WORDS=1, RUN lasts exactly one cycle.
- Reset (any state, including mid-RUN): state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, carry=0, idx=0. A partial computation is discarded with no done pulse.

## Timing
- Start accepted at clock edge k. busy=1 during cycles k+1 … k+WORDS.
- done=1 for the single cycle after the last RUN cycle, i.e. WORDS+1 cycles after acceptance.
- Back-to-back operation: start held during DONE gives a throughput of one operation per WORDS+1 cycles.
- busy and done are never high together.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- ADDSUB_SEQ_OVF_EN defined:
  - ovf port exists.
  - On the last word, ovf ← (msb of A_w == msb of effective B_w) && (msb of sum ≠ msb of A_w).
  - ovf is registered alongside cout and reset to 0.
- ADDSUB_SEQ_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.

## Structure
- Shared package holds:
  - the state enumeration (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - an add/sub opcode constant (OP_ADD=1'b0, OP_SUB=1'b1);
  - a clog2 helper for idx sizing.
- One sub-module, addsub_word_slice: purely combinational BITWIDTH-bit a + (sub ? ~b : b) + cin → sum, cout.
- The sequencer owns all registers: state, idx, carry, latched operands, result, flags.

## Test plan
All scenarios use BITWIDTH=8, WORDS=4.
- Reset then idle: rst_n low mid-cycle → all outputs 0 immediately; start never seen → busy=0, done=0 indefinitely.
- Carry ripple across words: add 0x000000FF + 0x00000001 → result=0x00000100, cout=0. done arrives exactly 5 cycles after acceptance; busy is high for exactly 4 cycles.
- Full wrap: add 0xFFFFFFFF + 0x00000001 → result=0x00000000, cout=1. Subtract 0x00000000 − 0x00000001 → result=0xFFFFFFFF, cout=0 (borrow).
- Signed overflow (macro on): add 0x7FFFFFFF + 0x00000001 → result=0x80000000, ovf=1, cout=0. Subtract 0x12345678 − 0x02345678 → 0x10000000, ovf=0, cout=1.
- Back-to-back and ignored start:
  - start pulsed during RUN → no effect; latched operands unchanged.
  - start held in DONE with new operands 5+3 → next done 5 cycles later, result=0x00000008.
- Reset mid-operation: rst_n asserted on the 2nd RUN cycle → state IDLE, result=0, no done. A fresh start afterwards completes correctly.
